// File: rtl/apa102_pkg.sv
// Shared types, frame constants and the LED word builder for the APA102 strand driver.
package apa102_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_FRAME,
    ST_LED_FRAME,
    ST_END_FRAME
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [31:0] OFF_WORD   = 32'hE000_0000;
  localparam logic [2:0]  LED_HEADER = 3'b111;

  function automatic logic [31:0] led_word(input logic [4:0] brightness,
                                           input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {LED_HEADER, brightness, b, g, r};
  endfunction

endpackage

// File: rtl/apa102_word_shifter.sv
// SCK divider plus 32-bit MSB-first shifter; asks for the next word on the falling edge after bit 0.
module apa102_word_shifter #(
  parameter int CLK_DIV = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        more_i,
  input  logic [31:0] word_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        word_done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_q;
  logic          sck_q;
  logic [DW-1:0] div_q;
  logic [4:0]    bit_q;
  logic [31:0]   shreg_q;
  logic          tc;
  logic          fall;
  logic          load;

  assign tc          = active_q && (div_q == DW'(CLK_DIV - 1));
  assign fall        = tc && sck_q;
  assign word_done_o = fall && (bit_q == 5'd31);
  assign load        = start_i || (word_done_o && more_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= word_i;
    end else if (active_q) begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) sck_q <= ~sck_q;
      if (fall) begin
        // Data only moves on falling edges so the strand samples stable bits on rising edges.
        if (bit_q == 5'd31) begin
          bit_q <= '0;
          if (load) begin
            shreg_q <= word_i;
          end else begin
            shreg_q  <= '0;
            active_q <= 1'b0;
          end
        end else begin
          bit_q   <= bit_q + 1'b1;
          shreg_q <= {shreg_q[30:0], 1'b0};
        end
      end
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = shreg_q[31];

endmodule

// File: rtl/apa102_strand_driver.sv
// APA102 strand transmitter: start frame, one word per LED, length-scaled end frame.
// Chase mode, pattern register and frame counter exist only when STRAND_CHASE_EN is defined.
module apa102_strand_driver
  import apa102_pkg::*;
#(
  parameter int NUM_LEDS = 12,
  parameter int CLK_DIV  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [4:0] brightness,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [1:0] speed,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       frame_done
);

  localparam int END_WORDS = (NUM_LEDS + 63) / 64;
  localparam int WCW       = $clog2(NUM_LEDS + 1);
  localparam logic [WCW-1:0] LAST_LED = WCW'(NUM_LEDS - 1);
  localparam logic [WCW-1:0] LAST_END = WCW'(END_WORDS - 1);

  state_e          state_q;
  mode_e           mode_q;
  logic [31:0]     lit_word_q;
  logic [WCW-1:0]  word_cnt_q;
  logic            busy_q;
  logic            frame_done_q;

  logic            accept;
  logic            word_done;
  logic            frame_end;
  logic            more;
  logic [WCW-1:0]  next_idx;
  logic [31:0]     next_word;
  logic [31:0]     shift_word;
  logic [NUM_LEDS:0] lit_vec;

  // A start seen during the frame_done cycle is dropped; the next cycle may accept.
  assign accept     = (state_q == ST_IDLE) && start && !frame_done_q;
  assign frame_end  = word_done && (state_q == ST_END_FRAME) && (word_cnt_q == LAST_END);
  assign shift_word = (state_q == ST_IDLE) ? START_WORD : next_word;

`ifdef STRAND_CHASE_EN
  logic [NUM_LEDS-1:0] pattern_q;
  logic [1:0]          frame_cnt_q;
  logic [1:0]          speed_q;
  logic [1:0]          step_at;

  // Speed 3 would need a wider counter; it saturates to a step every 4th frame.
  assign step_at = 2'((3'd1 << speed_q) - 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q   <= '0;
      frame_cnt_q <= '0;
      speed_q     <= '0;
    end else begin
      if (accept) speed_q <= speed;
      if (frame_end && (mode_q == MODE_CHASE)) begin
        if (frame_cnt_q == step_at) begin
          frame_cnt_q <= '0;
          pattern_q   <= (pattern_q == '0) ? NUM_LEDS'(1) : (pattern_q << 1);
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end
`else
  logic speed_unused;
  assign speed_unused = ^speed;
`endif

  always_comb begin
    lit_vec = '0;
    case (mode_q)
      MODE_OFF:   lit_vec = '0;
`ifdef STRAND_CHASE_EN
      MODE_CHASE: lit_vec = {1'b0, pattern_q};
`endif
      default:    lit_vec = {1'b0, {NUM_LEDS{1'b1}}};
    endcase
  end

  always_comb begin
    next_idx  = (state_q == ST_START_FRAME) ? '0 : word_cnt_q + 1'b1;
    more      = 1'b1;
    next_word = lit_vec[next_idx] ? lit_word_q : OFF_WORD;
    if ((state_q == ST_LED_FRAME) && (word_cnt_q == LAST_LED)) next_word = END_WORD;
    if (state_q == ST_END_FRAME) begin
      next_word = END_WORD;
      more      = (word_cnt_q != LAST_END);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_OFF;
      lit_word_q   <= '0;
      word_cnt_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q    <= ST_START_FRAME;
          mode_q     <= mode_e'(mode);
          lit_word_q <= led_word(brightness, red, green, blue);
          word_cnt_q <= '0;
          busy_q     <= 1'b1;
        end
        ST_START_FRAME: if (word_done) begin
          state_q    <= ST_LED_FRAME;
          word_cnt_q <= '0;
        end
        ST_LED_FRAME: if (word_done) begin
          if (word_cnt_q == LAST_LED) begin
            state_q    <= ST_END_FRAME;
            word_cnt_q <= '0;
          end else begin
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end
        ST_END_FRAME: if (frame_end) begin
          state_q      <= ST_IDLE;
          word_cnt_q   <= '0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end else if (word_done) begin
          word_cnt_q <= word_cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  apa102_word_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (accept),
    .more_i      (more),
    .word_i      (shift_word),
    .sck_o       (sck),
    .mosi_o      (mosi),
    .word_done_o (word_done)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_apa102_strand_driver.sv
// Bench for apa102_strand_driver: frame-level model checked every cycle plus literal frame checks.
module tb_apa102_strand_driver;

  localparam int NUM_LEDS    = 4;
  localparam int CLK_DIV     = 2;
  localparam int END_WORDS   = (NUM_LEDS + 63) / 64;
  localparam int FRAME_WORDS = 1 + NUM_LEDS + END_WORDS;
  localparam int FRAME_BITS  = 32 * FRAME_WORDS;
  localparam int T_END       = FRAME_BITS * 2 * CLK_DIV;
`ifdef STRAND_CHASE_EN
  localparam bit          CHASE_EN = 1'b1;
  localparam logic [23:0] EXP_T4   = 24'h012480;
  localparam logic [23:0] EXP_T5   = 24'h111122;
  localparam logic [3:0]  EXP_T7   = 4'h0;
`else
  localparam bit          CHASE_EN = 1'b0;
  localparam logic [23:0] EXP_T4   = 24'hFFFFFF;
  localparam logic [23:0] EXP_T5   = 24'hFFFFFF;
  localparam logic [3:0]  EXP_T7   = 4'hF;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] speed = 2'd0;
  logic [4:0] brightness = 5'd0;
  logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
  logic       sck, mosi, busy, frame_done;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  int          m_t = -1;
  bit          m_accept_next = 1'b0;
  logic [1:0]  m_mode, m_speed;
  logic [31:0] m_lit;
  int          m_pos = -1;
  int          m_fcnt = 0;
  logic [31:0] m_words [FRAME_WORDS];

  // observations
  logic                cap_bits[$];
  logic [31:0]         word_q[$];
  logic [NUM_LEDS-1:0] mask_q[$];
  int                  fd_count = 0;
  int                  busy_cycles = 0;
  int                  last_bits = 0;
  logic                prev_sck = 1'b0;

  apa102_strand_driver #(
    .NUM_LEDS(NUM_LEDS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .brightness (brightness),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .speed      (speed),
    .sck        (sck),
    .mosi       (mosi),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_frame();
    bit lit;
    m_words[0] = 32'h0000_0000;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (m_mode == 2'd0) lit = 1'b0;
      else if (m_mode == 2'd2 && CHASE_EN) lit = (m_pos == i);
      else lit = 1'b1;
      m_words[1 + i] = lit ? m_lit : 32'hE000_0000;
    end
    for (int e = 0; e < END_WORDS; e++) m_words[1 + NUM_LEDS + e] = 32'hFFFF_FFFF;
  endfunction

  function automatic void chase_advance();
    int period;
    if (CHASE_EN && m_mode == 2'd2) begin
      period = (m_speed == 2'd3) ? 4 : (1 << m_speed);
      m_fcnt++;
      if (m_fcnt == period) begin
        m_fcnt = 0;
        m_pos  = (m_pos == NUM_LEDS - 1) ? -1 : m_pos + 1;
      end
    end
  endfunction

  // Single compare process: model timeline vs DUT on every falling clock edge.
  always @(negedge clk) begin
    bit                  can_accept;
    int                  bi;
    logic [31:0]         wd;
    logic [NUM_LEDS-1:0] mk;
    can_accept = 1'b0;
    if (!reset_n) begin
      m_t = -1; m_accept_next = 1'b0; m_pos = -1; m_fcnt = 0;
      cap_bits.delete();
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
    end else begin
      if (m_accept_next) begin
        m_accept_next = 1'b0;
        m_t = 0;
        build_frame();
        cap_bits.delete();
      end
      if (busy) busy_cycles++;
      if (frame_done) fd_count++;
      if (sck && !prev_sck) cap_bits.push_back(mosi);
      if (m_t >= 0 && m_t < T_END) begin
        bi = m_t / (2 * CLK_DIV);
        check("busy", busy, 1);
        check("frame_done", frame_done, 0);
        check("sck", sck, (m_t / CLK_DIV) % 2);
        check("mosi", mosi, m_words[bi / 32][31 - (bi % 32)]);
        m_t++;
      end else if (m_t == T_END) begin
        check("end_busy", busy, 0);
        check("end_frame_done", frame_done, 1);
        check("end_sck", sck, 0);
        check("end_mosi", mosi, 0);
        last_bits = cap_bits.size();
        check("frame_bits", last_bits, FRAME_BITS);
        mk = '0;
        for (int w = 0; w < FRAME_WORDS; w++) begin
          wd = '0;
          for (int k = 0; k < 32; k++)
            wd = {wd[30:0], (32 * w + k < cap_bits.size()) ? cap_bits[32 * w + k] : 1'b0};
          word_q.push_back(wd);
          if (w >= 1 && w <= NUM_LEDS) mk[w - 1] = (wd != 32'hE000_0000);
        end
        mask_q.push_back(mk);
        chase_advance();
        m_t = -1;
      end else begin
        check("idle_sck", sck, 0);
        check("idle_mosi", mosi, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_done", frame_done, 0);
        can_accept = 1'b1;
      end
      if (can_accept && start) begin
        m_accept_next = 1'b1;
        m_mode  = mode;
        m_speed = speed;
        m_lit   = {3'b111, brightness, blue, green, red};
      end
    end
    prev_sck = sck;
  end

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while ((m_t >= 0 || m_accept_next) && cyc < 2 * T_END);
    check({tag, "_idle_in_time"}, (cyc < 2 * T_END), 1);
    #2;
  endtask

  // Holds start high so frames run back to back, dropping it after n frame_done pulses.
  task automatic run_frames(input string tag, input int n, input logic [1:0] md,
                            input logic [4:0] br, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [1:0] sp);
    int fd0, cyc;
    @(posedge clk); #2;
    mode = md; brightness = br; red = r; green = g; blue = b; speed = sp;
    word_q.delete(); mask_q.delete();
    fd0 = fd_count; cyc = 0;
    start = 1'b1;
    while ((fd_count - fd0) < n && cyc < n * (T_END + 10)) begin
      @(posedge clk);
      cyc++;
    end
    #2 start = 1'b0;
    check({tag, "_frames_in_time"}, (cyc < n * (T_END + 10)), 1);
    wait_idle(tag);
    check({tag, "_frame_count"}, fd_count - fd0, n);
  endtask

  task automatic expect_words(input string tag, input logic [31:0] led);
    logic [31:0] got, exp;
    check({tag, "_nwords"}, word_q.size(), 6);
    for (int w = 0; w < 6; w++) begin
      got = (word_q.size() > 0) ? word_q.pop_front() : 32'hxxxx_xxxx;
      exp = (w == 0) ? 32'h0000_0000 : (w == 5) ? 32'hFFFF_FFFF : led;
      check($sformatf("%s_word%0d", tag, w), got, exp);
    end
  endtask

  task automatic expect_masks(input string tag, input logic [23:0] exp_masks);
    logic [3:0] got;
    check({tag, "_nmasks"}, mask_q.size(), 6);
    for (int f = 0; f < 6; f++) begin
      got = (mask_q.size() > 0) ? mask_q.pop_front() : 4'hx;
      check($sformatf("%s_mask%0d", tag, f), got, exp_masks[23 - 4 * f -: 4]);
    end
  endtask

  initial begin
    int fd_base, cyc;
    logic [3:0] mk7;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // solid frame: timing and contents pinned by literals
    busy_cycles = 0; fd_base = fd_count;
    run_frames("t1", 1, 2'd1, 5'h18, 8'hF4, 8'h7A, 8'h42, 2'd0);
    check("t1_busy_cycles", busy_cycles, 768);
    check("t1_bits", last_bits, 192);
    check("t1_done_pulses", fd_count - fd_base, 1);
    expect_words("t1", 32'hF842_7AF4);

    run_frames("t2", 1, 2'd0, 5'h1F, 8'hFF, 8'hFF, 8'hFF, 2'd0);
    expect_words("t2", 32'hE000_0000);

    run_frames("t3", 1, 2'd3, 5'h1F, 8'h01, 8'h02, 8'h03, 2'd0);
    expect_words("t3", 32'hFF03_0201);

    run_frames("t4", 6, 2'd2, 5'h0F, 8'h10, 8'h20, 8'h30, 2'd0);
    expect_masks("t4", EXP_T4);

    run_frames("t5", 6, 2'd2, 5'h0F, 8'h10, 8'h20, 8'h30, 2'd2);
    expect_masks("t5", EXP_T5);

    // extra start pulse in mid-frame must be dropped
    fd_base = fd_count;
    @(posedge clk); #2;
    mode = 2'd1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (300) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_idle("t6");
    repeat (20) @(posedge clk);
    check("t6_done_pulses", fd_count - fd_base, 1);
    check("t6_busy_after", busy, 0);

    // reset at bit 50 of a chase frame, then a fresh frame with cleared pattern
    @(posedge clk); #2;
    mode = 2'd2; speed = 2'd0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cyc = 0;
    while (m_t < 50 * 2 * CLK_DIV && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    check("t7_reach_bit50", (cyc < 2000), 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("t7_abort_sck", sck, 0);
    check("t7_abort_mosi", mosi, 0);
    check("t7_abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frames("t7", 1, 2'd2, 5'h0F, 8'h10, 8'h20, 8'h30, 2'd0);
    mk7 = (mask_q.size() > 0) ? mask_q.pop_front() : 4'hx;
    check("t7_mask", mk7, EXP_T7);
    check("t7_first_word", (word_q.size() > 0) ? word_q[0] : 32'hxxxx_xxxx, 32'h0000_0000);
    check("t7_bits", last_bits, 192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
